reset_seq: RTL and testbench

RESET_SEQ -- requirements
Module: reset_seq

---
 rtl/reset_seq_pkg.sv | 36 +++
 rtl/rst_sync.sv | 31 +++
 rtl/reset_seq.sv | 164 ++++++++++++++++
 tb/tb_reset_seq.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reset_seq_pkg
// Description : Shared types, constants and helpers for the reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package reset_seq_pkg;

  // Width of every cycle counter in the sequencer.
  localparam int C_CNT_W = 16;
  localparam logic [C_CNT_W-1:0] C_CNT_MAX = '1;

  // Default parameter values of the top-level sequencer.
  localparam int C_DEF_N_STAGES      = 3;
  localparam int C_DEF_HOLD_CYCLES   = 256;
  localparam int C_DEF_GAP_CYCLES    = 16;
  localparam int C_DEF_READY_TIMEOUT = 4096;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_SYNC       = 3'd0,
    ST_HOLD       = 3'd1,
    ST_RELEASE    = 3'd2,
    ST_WAIT_READY = 3'd3,
    ST_GAP        = 3'd4,
    ST_RUN        = 3'd5,
    ST_FAULT      = 3'd6
  } state_t;

  // Increment that sticks at the maximum instead of wrapping to zero.
  function automatic logic [C_CNT_W-1:0] sat_inc(input logic [C_CNT_W-1:0] v);
    return (v == C_CNT_MAX) ? v : v + C_CNT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rst_sync.sv
`default_nettype none
// ============================================================================
// Module      : rst_sync
// Description : Two-flop reset synchroniser, asynchronous assert and
//               synchronous release; reusable in any clock domain.
// Revision    : 1.0 - initial release
// ============================================================================
module rst_sync (
  input  logic clk,
  input  logic rst_in,
  output logic rst_out
);

  logic r_meta;
  logic r_sync;

  // Both flops preset immediately on reset; a 0 ripples in over two edges.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= 1'b0;
      r_sync <= r_meta;
    end
  end

  assign rst_out = r_sync;

endmodule
`default_nettype wire

// File: rtl/reset_seq.sv
`default_nettype none
// ============================================================================
// Module      : reset_seq
// Description : Multi-domain reset sequencer. Holds all stages in reset after
//               a synchronised release, then releases them one at a time,
//               waiting for each stage's ready before the next one. Supports
//               a software re-run request and a sticky ready-timeout fault.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int N_STAGES      = C_DEF_N_STAGES,
  parameter int HOLD_CYCLES   = C_DEF_HOLD_CYCLES,
  parameter int GAP_CYCLES    = C_DEF_GAP_CYCLES,
  parameter int READY_TIMEOUT = C_DEF_READY_TIMEOUT
) (
  input  logic                clk_256fs,
  input  logic                rst,
  input  logic                soft_rst_req,
  input  logic [N_STAGES-1:0] stage_ready,
  output logic [N_STAGES-1:0] rst_stage,
  output logic                soft_rst_ack,
  output logic                all_up,
  output logic                fault
);

  localparam int IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  // Terminal counts; GAP of zero collapses to "leave on first cycle".
  localparam logic [C_CNT_W-1:0] C_HOLD_LAST = C_CNT_W'(HOLD_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] C_GAP_LAST  =
    C_CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  // The timeout counter starts on the RELEASE cycle, so the fault lands
  // exactly READY_TIMEOUT edges after the stage was released.
  localparam logic [C_CNT_W-1:0] C_TO_LAST   = C_CNT_W'(READY_TIMEOUT - 1);
  localparam logic [IDX_W-1:0]   C_IDX_LAST  = IDX_W'(N_STAGES - 1);

  logic                 w_sync_rst;
  state_t               r_state,     w_state_nxt;
  logic [IDX_W-1:0]     r_idx,       w_idx_nxt;
  logic [IDX_W-1:0]     w_idx_inc;
  logic [C_CNT_W-1:0]   r_cnt,       w_cnt_nxt;
  logic [N_STAGES-1:0]  r_rst_stage, w_rst_stage_nxt;
  logic                 r_ack,       w_ack_nxt;
  logic                 r_all_up,    w_all_up_nxt;
  logic                 r_fault,     w_fault_nxt;
  logic                 r_armed,     w_armed_nxt;

  rst_sync u_rst_sync (
    .clk     (clk_256fs),
    .rst_in  (rst),
    .rst_out (w_sync_rst)
  );

  assign w_idx_inc = r_idx + IDX_W'(1);

  // Next-state, counter, stage-reset and status decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_cnt_nxt       = sat_inc(r_cnt);
    w_rst_stage_nxt = r_rst_stage;
    w_ack_nxt       = 1'b0;
    w_fault_nxt     = r_fault;
    // A held request must be seen low once before it can fire again.
    w_armed_nxt     = r_armed | ~soft_rst_req;

    if ((r_state != ST_SYNC) && soft_rst_req && r_armed) begin
      // Soft reset wins over everything, including a same-cycle timeout.
      w_state_nxt     = ST_HOLD;
      w_idx_nxt       = '0;
      w_cnt_nxt       = '0;
      w_rst_stage_nxt = '1;
      w_ack_nxt       = 1'b1;
      w_fault_nxt     = 1'b0;
      w_armed_nxt     = 1'b0;
    end else begin
      case (r_state)
        ST_SYNC: begin
          w_cnt_nxt = '0;
          if (!w_sync_rst) begin
            w_state_nxt = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (r_cnt >= C_HOLD_LAST) begin
            w_state_nxt        = ST_RELEASE;
            w_idx_nxt          = '0;
            w_cnt_nxt          = '0;
            w_rst_stage_nxt[0] = 1'b0;
          end
        end
        ST_RELEASE: begin
          w_state_nxt = ST_WAIT_READY;
        end
        ST_WAIT_READY: begin
          if (stage_ready[r_idx]) begin
            w_state_nxt = (r_idx == C_IDX_LAST) ? ST_RUN : ST_GAP;
            w_cnt_nxt   = '0;
          end else if (r_cnt >= C_TO_LAST) begin
            w_state_nxt = ST_FAULT;
            w_cnt_nxt   = '0;
            w_fault_nxt = 1'b1;
          end
        end
        ST_GAP: begin
          if (r_cnt >= C_GAP_LAST) begin
            w_state_nxt                = ST_RELEASE;
            w_idx_nxt                  = w_idx_inc;
            w_cnt_nxt                  = '0;
            w_rst_stage_nxt[w_idx_inc] = 1'b0;
          end
        end
        ST_RUN: begin
          w_cnt_nxt = '0;
        end
        ST_FAULT: begin
          w_cnt_nxt = '0;
        end
        default: begin
          w_state_nxt     = ST_SYNC;
          w_idx_nxt       = '0;
          w_cnt_nxt       = '0;
          w_rst_stage_nxt = '1;
        end
      endcase
    end

    // Decoded from the next state so all_up rises on the edge RUN is entered
    // and follows stage_ready with one cycle of latency.
    w_all_up_nxt = (w_state_nxt == ST_RUN) && (&stage_ready);
  end

  // State and output registers; reset forces the safe state at once.
  always_ff @(posedge clk_256fs or posedge rst) begin
    if (rst) begin
      r_state     <= ST_SYNC;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_rst_stage <= '1;
      r_ack       <= 1'b0;
      r_all_up    <= 1'b0;
      r_fault     <= 1'b0;
      r_armed     <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rst_stage <= w_rst_stage_nxt;
      r_ack       <= w_ack_nxt;
      r_all_up    <= w_all_up_nxt;
      r_fault     <= w_fault_nxt;
      r_armed     <= w_armed_nxt;
    end
  end

  assign rst_stage    = r_rst_stage;
  assign soft_rst_ack = r_ack;
  assign all_up       = r_all_up;
  assign fault        = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_reset_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_reset_seq
// Description : Self-checking bench for reset_seq with a timed scoreboard of
//               expected {rst_stage, all_up, fault, soft_rst_ack} snapshots.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_seq;

  localparam int LIMIT = 200;

  logic       clk_256fs;
  logic       rst;
  logic       soft_rst_req;
  logic [2:0] stage_ready;
  logic [2:0] rst_stage;
  logic       soft_rst_ack;
  logic       all_up;
  logic       fault;
  logic [5:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         cyc;
    logic [5:0] val;
    string      tag;
  } exp_t;

  exp_t sb_q[$];

  reset_seq #(
    .N_STAGES      (3),
    .HOLD_CYCLES   (8),
    .GAP_CYCLES    (4),
    .READY_TIMEOUT (32)
  ) dut (
    .clk_256fs    (clk_256fs),
    .rst          (rst),
    .soft_rst_req (soft_rst_req),
    .stage_ready  (stage_ready),
    .rst_stage    (rst_stage),
    .soft_rst_ack (soft_rst_ack),
    .all_up       (all_up),
    .fault        (fault)
  );

  assign obs = {rst_stage, all_up, fault, soft_rst_ack};

  initial clk_256fs = 1'b0;
  always #5 clk_256fs = ~clk_256fs;

  // Queue an expected snapshot at edge c (edges counted from rst release).
  function automatic void expect_at(int c, logic [2:0] rs, logic au, logic f,
                                    logic ak, string tag);
    exp_t x;
    x.cyc = c;
    x.val = {rs, au, f, ak};
    x.tag = tag;
    sb_q.push_back(x);
  endfunction

  // Hold rst for three edges, then release it 1 time unit after an edge.
  task automatic apply_rst();
    rst          = 1'b1;
    soft_rst_req = 1'b0;
    repeat (3) @(posedge clk_256fs);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    stage_ready  = 3'b111;
    rst          = 1'b1;
    soft_rst_req = 1'b0;
    repeat (2) @(posedge clk_256fs);
    #1;
    n_checks++;
    if (obs !== 6'b111_0_0_0) begin
      n_fail++;
      $display("FAIL reset_values: got %b want %b", obs, 6'b111_0_0_0);
    end
    soft_rst_req = 1'b1;
    repeat (2) @(posedge clk_256fs);
    #1;
    n_checks++;
    if (obs !== 6'b111_0_0_0) begin
      n_fail++;
      $display("FAIL reset_soft_ignored: got %b want %b", obs, 6'b111_0_0_0);
    end
    soft_rst_req = 1'b0;
  endtask

  task automatic test_power_on();
    stage_ready = 3'b111;
    apply_rst();
    expect_at( 1, 3'b111, 0, 0, 0, "po_sync");
    expect_at(10, 3'b111, 0, 0, 0, "po_hold_end");
    expect_at(11, 3'b110, 0, 0, 0, "po_rel0");
    expect_at(16, 3'b110, 0, 0, 0, "po_gap0_end");
    expect_at(17, 3'b100, 0, 0, 0, "po_rel1");
    expect_at(22, 3'b100, 0, 0, 0, "po_gap1_end");
    expect_at(23, 3'b000, 0, 0, 0, "po_rel2");
    expect_at(24, 3'b000, 0, 0, 0, "po_wait2");
    expect_at(25, 3'b000, 1, 0, 0, "po_all_up");
    expect_at(31, 3'b000, 0, 0, 0, "run_ready_drop");
    expect_at(33, 3'b000, 1, 0, 0, "run_ready_back");
    for (int e = 1; e <= LIMIT && sb_q.size() != 0; e++) begin
      @(posedge clk_256fs);
      #1;
      while (sb_q.size() != 0 && sb_q[0].cyc == e) begin
        exp_t x;
        x = sb_q.pop_front();
        n_checks++;
        if (obs !== x.val) begin
          n_fail++;
          $display("FAIL %s @edge %0d: got %b want %b", x.tag, e, obs, x.val);
        end
      end
      if (e == 30) stage_ready = 3'b101;
      if (e == 32) stage_ready = 3'b111;
    end
    while (sb_q.size() != 0) begin
      exp_t x;
      x = sb_q.pop_front();
      n_checks++; n_fail++;
      $display("FAIL %s: edge %0d never reached", x.tag, x.cyc);
    end
  endtask

  task automatic test_timeout();
    stage_ready = 3'b101;
    apply_rst();
    expect_at(11, 3'b110, 0, 0, 0, "to_rel0");
    expect_at(17, 3'b100, 0, 0, 0, "to_rel1");
    expect_at(48, 3'b100, 0, 0, 0, "to_before");
    expect_at(49, 3'b100, 0, 1, 0, "to_fault");
    expect_at(60, 3'b100, 0, 1, 0, "to_sticky");
    for (int e = 1; e <= LIMIT && sb_q.size() != 0; e++) begin
      @(posedge clk_256fs);
      #1;
      while (sb_q.size() != 0 && sb_q[0].cyc == e) begin
        exp_t x;
        x = sb_q.pop_front();
        n_checks++;
        if (obs !== x.val) begin
          n_fail++;
          $display("FAIL %s @edge %0d: got %b want %b", x.tag, e, obs, x.val);
        end
      end
    end
    while (sb_q.size() != 0) begin
      exp_t x;
      x = sb_q.pop_front();
      n_checks++; n_fail++;
      $display("FAIL %s: edge %0d never reached", x.tag, x.cyc);
    end
  endtask

  task automatic test_soft_in_run();
    stage_ready = 3'b111;
    apply_rst();
    expect_at(30, 3'b000, 1, 0, 0, "sr_run");
    expect_at(31, 3'b111, 0, 0, 1, "sr_ack");
    expect_at(32, 3'b111, 0, 0, 0, "sr_ack_once");
    expect_at(38, 3'b111, 0, 0, 0, "sr_hold_end");
    expect_at(39, 3'b110, 0, 0, 0, "sr_rel0");
    expect_at(44, 3'b110, 0, 0, 0, "sr_gap0_end");
    expect_at(45, 3'b100, 0, 0, 0, "sr_rel1");
    expect_at(51, 3'b000, 0, 0, 0, "sr_rel2");
    expect_at(52, 3'b000, 0, 0, 0, "sr_wait2");
    expect_at(53, 3'b000, 1, 0, 0, "sr_all_up");
    for (int e = 1; e <= LIMIT && sb_q.size() != 0; e++) begin
      @(posedge clk_256fs);
      #1;
      while (sb_q.size() != 0 && sb_q[0].cyc == e) begin
        exp_t x;
        x = sb_q.pop_front();
        n_checks++;
        if (obs !== x.val) begin
          n_fail++;
          $display("FAIL %s @edge %0d: got %b want %b", x.tag, e, obs, x.val);
        end
      end
      if (e == 30) soft_rst_req = 1'b1;
      if (e == 31) soft_rst_req = 1'b0;
    end
    while (sb_q.size() != 0) begin
      exp_t x;
      x = sb_q.pop_front();
      n_checks++; n_fail++;
      $display("FAIL %s: edge %0d never reached", x.tag, x.cyc);
    end
  endtask

  task automatic test_soft_held();
    int acks;
    acks = 0;
    stage_ready = 3'b111;
    apply_rst();
    expect_at(31, 3'b111, 0, 0, 1, "sh_ack1");
    expect_at(32, 3'b111, 0, 0, 0, "sh_no_retrig");
    expect_at(60, 3'b000, 1, 0, 0, "sh_run_held");
    expect_at(81, 3'b000, 1, 0, 0, "sh_low_cycle");
    expect_at(82, 3'b111, 0, 0, 1, "sh_ack2");
    expect_at(83, 3'b111, 0, 0, 0, "sh_ack2_once");
    for (int e = 1; e <= LIMIT && sb_q.size() != 0; e++) begin
      @(posedge clk_256fs);
      #1;
      if (soft_rst_ack) acks++;
      while (sb_q.size() != 0 && sb_q[0].cyc == e) begin
        exp_t x;
        x = sb_q.pop_front();
        n_checks++;
        if (obs !== x.val) begin
          n_fail++;
          $display("FAIL %s @edge %0d: got %b want %b", x.tag, e, obs, x.val);
        end
      end
      if (e == 30) soft_rst_req = 1'b1;
      if (e == 80) soft_rst_req = 1'b0;
      if (e == 81) soft_rst_req = 1'b1;
      if (e == 82) soft_rst_req = 1'b0;
    end
    while (sb_q.size() != 0) begin
      exp_t x;
      x = sb_q.pop_front();
      n_checks++; n_fail++;
      $display("FAIL %s: edge %0d never reached", x.tag, x.cyc);
    end
    n_checks++;
    if (acks !== 2) begin
      n_fail++;
      $display("FAIL sh_ack_count: got %0d want %0d", acks, 2);
    end
  endtask

  task automatic test_async_rst();
    stage_ready = 3'b101;
    apply_rst();
    expect_at(25, 3'b100, 0, 0, 0, "ar_in_wait");
    for (int e = 1; e <= LIMIT && sb_q.size() != 0; e++) begin
      @(posedge clk_256fs);
      #1;
      while (sb_q.size() != 0 && sb_q[0].cyc == e) begin
        exp_t x;
        x = sb_q.pop_front();
        n_checks++;
        if (obs !== x.val) begin
          n_fail++;
          $display("FAIL %s @edge %0d: got %b want %b", x.tag, e, obs, x.val);
        end
      end
    end
    while (sb_q.size() != 0) begin
      exp_t x;
      x = sb_q.pop_front();
      n_checks++; n_fail++;
      $display("FAIL %s: edge %0d never reached", x.tag, x.cyc);
    end
    // Mid-cycle pulse: outputs must reset before any further clock edge.
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== 6'b111_0_0_0) begin
      n_fail++;
      $display("FAIL ar_immediate: got %b want %b", obs, 6'b111_0_0_0);
    end
    stage_ready = 3'b111;
    #1;
    rst = 1'b0;
    expect_at( 2, 3'b111, 0, 0, 0, "ar_sync");
    expect_at(10, 3'b111, 0, 0, 0, "ar_hold_end");
    expect_at(11, 3'b110, 0, 0, 0, "ar_rel0");
    expect_at(17, 3'b100, 0, 0, 0, "ar_rel1");
    expect_at(23, 3'b000, 0, 0, 0, "ar_rel2");
    expect_at(25, 3'b000, 1, 0, 0, "ar_all_up");
    for (int e = 1; e <= LIMIT && sb_q.size() != 0; e++) begin
      @(posedge clk_256fs);
      #1;
      while (sb_q.size() != 0 && sb_q[0].cyc == e) begin
        exp_t x;
        x = sb_q.pop_front();
        n_checks++;
        if (obs !== x.val) begin
          n_fail++;
          $display("FAIL %s @edge %0d: got %b want %b", x.tag, e, obs, x.val);
        end
      end
    end
    while (sb_q.size() != 0) begin
      exp_t x;
      x = sb_q.pop_front();
      n_checks++; n_fail++;
      $display("FAIL %s: edge %0d never reached", x.tag, x.cyc);
    end
  endtask

  task automatic test_soft_vs_timeout();
    stage_ready = 3'b101;
    apply_rst();
    expect_at(48, 3'b100, 0, 0, 0, "st_before");
    expect_at(49, 3'b111, 0, 0, 1, "st_soft_wins");
    expect_at(50, 3'b111, 0, 0, 0, "st_no_fault");
    expect_at(56, 3'b111, 0, 0, 0, "st_hold_end");
    expect_at(57, 3'b110, 0, 0, 0, "st_rel0");
    expect_at(63, 3'b100, 0, 0, 0, "st_rel1");
    for (int e = 1; e <= LIMIT && sb_q.size() != 0; e++) begin
      @(posedge clk_256fs);
      #1;
      while (sb_q.size() != 0 && sb_q[0].cyc == e) begin
        exp_t x;
        x = sb_q.pop_front();
        n_checks++;
        if (obs !== x.val) begin
          n_fail++;
          $display("FAIL %s @edge %0d: got %b want %b", x.tag, e, obs, x.val);
        end
      end
      if (e == 48) soft_rst_req = 1'b1;
      if (e == 49) soft_rst_req = 1'b0;
    end
    while (sb_q.size() != 0) begin
      exp_t x;
      x = sb_q.pop_front();
      n_checks++; n_fail++;
      $display("FAIL %s: edge %0d never reached", x.tag, x.cyc);
    end
  endtask

  initial begin
    rst          = 1'b1;
    soft_rst_req = 1'b0;
    stage_ready  = 3'b000;
    test_reset();
    test_power_on();
    test_timeout();
    test_soft_in_run();
    test_soft_held();
    test_async_rst();
    test_soft_vs_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
